// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini RV32I CPU execute/memory slice.
// Holds the ALU operation enum, the opcode constants and the funct3 codes
// used by control decode.
package mini_cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

endpackage

// File: rtl/alu_control_mem_if.sv
// Bundle between the register file / immediate generator side and the
// execute/memory slice.
//   master: drives instr, rs1_data, rs2_data, imm; receives results.
//   slave : the alu_control_mem block itself.
interface alu_control_mem_if;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] wb_data;
  logic        reg_write;
  logic        branch_taken;
  logic        illegal;

  modport master (
    output instr, rs1_data, rs2_data, imm,
    input  alu_result, zero, wb_data, reg_write, branch_taken, illegal
  );

  modport slave (
    input  instr, rs1_data, rs2_data, imm,
    output alu_result, zero, wb_data, reg_write, branch_taken, illegal
  );
endinterface

// File: rtl/alu.sv
// 32-bit combinational ALU.
// Ports: a, b (operands), op (alu_op_t), result, zero (result == 0).
// MINI_CPU_SHIFT_EN: when defined, SLL/SRL/SRA are built; otherwise the
// shifter is absent and those ops yield 0 (control never selects them then).
module alu
  import mini_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'b0, (a < b)};
`ifdef MINI_CPU_SHIFT_EN
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
`endif
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_control_mem.sv
// Execute/memory slice of the mini single-cycle RV32I CPU: control decode,
// ALU and a word-addressed data memory.
// Ports: clk, rst_n (async active-low, clears the memory),
//        bus (alu_control_mem_if.slave: instr, rs1_data, rs2_data, imm in;
//        alu_result, zero, wb_data, reg_write, branch_taken, illegal out).
// Parameter DEPTH: memory depth in 32-bit words, power of two.
// MINI_CPU_SHIFT_EN: enables SLL/SRL/SRA/SLLI/SRLI/SRAI; otherwise they
// decode as illegal.
module alu_control_mem
  import mini_cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_control_mem_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

`ifdef MINI_CPU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic        legal;
  logic        use_rs2;
  logic        writes_reg;
  logic        is_load;
  logic        is_store;
  logic        is_branch;
  alu_op_t     dec_op;
  alu_op_t     alu_op;
  logic [31:0] operand_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] word_idx;
  logic        mem_we;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign alt    = bus.instr[30];

  // Remaining instruction bits belong to register/immediate fields decoded elsewhere.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  always_comb begin
    legal      = 1'b0;
    use_rs2    = 1'b0;
    writes_reg = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    dec_op     = ALU_ADD;
    case (opcode)
      OP_R, OP_IMM: begin
        use_rs2    = (opcode == OP_R);
        writes_reg = 1'b1;
        case (funct3)
          F3_ADD_SUB: begin
            legal  = 1'b1;
            dec_op = (use_rs2 && alt) ? ALU_SUB : ALU_ADD;
          end
          F3_SLL: begin
            legal  = SHIFT_EN && !(use_rs2 && alt);
            dec_op = ALU_SLL;
          end
          F3_SLT: begin
            legal  = !(use_rs2 && alt);
            dec_op = ALU_SLT;
          end
          F3_SLTU: begin
            legal  = !(use_rs2 && alt);
            dec_op = ALU_SLTU;
          end
          F3_XOR: begin
            legal  = !(use_rs2 && alt);
            dec_op = ALU_XOR;
          end
          F3_SRL_SRA: begin
            legal  = SHIFT_EN;
            dec_op = alt ? ALU_SRA : ALU_SRL;
          end
          F3_OR: begin
            legal  = !(use_rs2 && alt);
            dec_op = ALU_OR;
          end
          default: begin
            legal  = !(use_rs2 && alt);
            dec_op = ALU_AND;
          end
        endcase
      end
      OP_LOAD: begin
        legal      = (funct3 == F3_LW);
        writes_reg = 1'b1;
        is_load    = 1'b1;
      end
      OP_STORE: begin
        legal    = (funct3 == F3_SW);
        is_store = 1'b1;
      end
      OP_BRANCH: begin
        legal     = (funct3 == F3_BEQ);
        use_rs2   = 1'b1;
        is_branch = 1'b1;
        dec_op    = ALU_SUB;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings fall back to ADD so alu_result stays well defined.
  assign alu_op    = legal ? dec_op : ALU_ADD;
  assign operand_b = use_rs2 ? bus.rs2_data : bus.imm;

  alu u_alu (
    .a      (bus.rs1_data),
    .b      (operand_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Byte address -> word index; upper bits wrap modulo DEPTH.
  assign word_idx = alu_result[AW+1:2];
  assign mem_we   = legal && is_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[word_idx] <= bus.rs2_data;
    end
  end

  assign bus.alu_result   = alu_result;
  assign bus.zero         = alu_zero;
  assign bus.wb_data      = (legal && is_load) ? mem[word_idx] : alu_result;
  assign bus.reg_write    = legal && writes_reg;
  assign bus.branch_taken = legal && is_branch && alu_zero;
  assign bus.illegal      = !legal;

endmodule

// File: tb/tb_alu_control_mem.sv
// Self-checking bench for alu_control_mem: directed cases plus randomized
// instructions compared against a behavioural model with its own memory image.
module tb_alu_control_mem;

  localparam int unsigned DEPTH = 64;

`ifdef MINI_CPU_SHIFT_EN
  localparam bit SHIFT_ON = 1'b1;
`else
  localparam bit SHIFT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_control_mem_if bus ();

  alu_control_mem #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] cur_ins, cur_r1, cur_r2, cur_im;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic alt);
    return {1'b0, alt, 15'b0, f3, 5'b0, opc};
  endfunction

  // Reference: RV32I semantics for the supported subset.
  function automatic void ref_exec(
    input  logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
    output logic [31:0] res, output logic [31:0] wb, output logic rw, output logic br,
    output logic ill, output logic st, output logic known);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       alt, legal, load, is_br, rtype;
    logic [31:0] b;
    int sh;
    opc = ins[6:0]; f3 = ins[14:12]; alt = ins[30];
    legal = 1'b0; load = 1'b0; is_br = 1'b0; rw = 1'b0; st = 1'b0; known = 1'b1;
    res = '0; b = im;
    rtype = (opc == 7'h33);
    case (opc)
      7'h33, 7'h13: begin
        b = rtype ? r2 : im;
        sh = int'(b % 32);
        rw = 1'b1;
        case (f3)
          3'd0: begin res = (rtype && alt) ? r1 - b : r1 + b; legal = 1'b1; end
          3'd1: begin res = r1 << sh; legal = SHIFT_ON && !(rtype && alt); end
          3'd2: begin res = ($signed(r1) < $signed(b)) ? 32'd1 : 32'd0; legal = !(rtype && alt); end
          3'd3: begin res = (r1 < b) ? 32'd1 : 32'd0; legal = !(rtype && alt); end
          3'd4: begin res = r1 ^ b; legal = !(rtype && alt); end
          3'd5: begin
            res = alt ? 32'($signed(r1) >>> sh) : (r1 >> sh);
            legal = SHIFT_ON;
          end
          3'd6: begin res = r1 | b; legal = !(rtype && alt); end
          default: begin res = r1 & b; legal = !(rtype && alt); end
        endcase
      end
      7'h03: begin res = r1 + im; legal = (f3 == 3'd2); load = 1'b1; rw = 1'b1; end
      7'h23: begin res = r1 + im; legal = (f3 == 3'd2); st = 1'b1; end
      7'h63: begin b = r2; res = r1 - r2; legal = (f3 == 3'd0); is_br = 1'b1; end
      default: known = 1'b0;
    endcase
    if (!legal) begin
      res = r1 + b; rw = 1'b0; st = 1'b0; is_br = 1'b0; load = 1'b0;
    end
    br  = is_br && (res == 32'd0);
    ill = !legal;
    wb  = load ? ref_mem[(res >> 2) % DEPTH] : res;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    @(negedge clk);
    bus.instr = ins; bus.rs1_data = r1; bus.rs2_data = r2; bus.imm = im;
    cur_ins = ins; cur_r1 = r1; cur_r2 = r2; cur_im = im;
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] res, wb;
    logic rw, br, ill, st, known;
    ref_exec(cur_ins, cur_r1, cur_r2, cur_im, res, wb, rw, br, ill, st, known);
    if (known) begin
      check({tag, ".alu"}, bus.alu_result, res);
      check({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, (res == 32'd0)});
      check({tag, ".wb"}, bus.wb_data, wb);
    end
    check({tag, ".rw"}, {31'b0, bus.reg_write}, {31'b0, rw});
    check({tag, ".br"}, {31'b0, bus.branch_taken}, {31'b0, br});
    check({tag, ".ill"}, {31'b0, bus.illegal}, {31'b0, ill});
  endtask

  // Advance one clock edge, mirroring a legal store into the model memory.
  task automatic step();
    logic [31:0] res, wb;
    logic rw, br, ill, st, known;
    ref_exec(cur_ins, cur_r1, cur_r2, cur_im, res, wb, rw, br, ill, st, known);
    @(posedge clk);
    if (rst_n && st) ref_mem[(res >> 2) % DEPTH] = cur_r2;
    #1;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
  endtask

  initial begin
    logic [6:0] opcs [6];
    logic [6:0] opc;
    logic [31:0] r1, r2, im, ins;
    opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h03;
    opcs[3] = 7'h23; opcs[4] = 7'h63; opcs[5] = 7'h00;
    clear_ref();
    bus.instr = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.imm = '0;
    cur_ins = '0; cur_r1 = '0; cur_r2 = '0; cur_im = '0;

    // During reset: combinational outputs live, loads read 0
    drive(mk(7'h03, 3'd2, 1'b0), 32'h0, 32'h0, 32'h8);
    check("rst_lw_wb", bus.wb_data, 32'h0);
    check("rst_lw_rw", {31'b0, bus.reg_write}, 32'd1);
    check_model("rst_lw");
    rst_n = 1'b1;

    drive(mk(7'h33, 3'd0, 1'b0), 32'd7, 32'd5, 32'h0);
    check("add_alu", bus.alu_result, 32'd12);
    check("add_wb", bus.wb_data, 32'd12);
    check("add_rw", {31'b0, bus.reg_write}, 32'd1);
    step();

    drive(mk(7'h33, 3'd0, 1'b1), 32'd5, 32'd7, 32'h0);
    check("sub_alu", bus.alu_result, 32'hFFFF_FFFE);
    step();

    drive(mk(7'h33, 3'd2, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'h0);
    check("slt_alu", bus.alu_result, 32'd1);
    step();
    drive(mk(7'h33, 3'd3, 1'b0), 32'hFFFF_FFFF, 32'd1, 32'h0);
    check("sltu_alu", bus.alu_result, 32'd0);
    step();

    drive(mk(7'h13, 3'd5, 1'b1), 32'h8000_0000, 32'h0, 32'h0000_0404);
`ifdef MINI_CPU_SHIFT_EN
    check("srai_alu", bus.alu_result, 32'hF800_0000);
    check("srai_rw", {31'b0, bus.reg_write}, 32'd1);
`else
    check("srai_ill", {31'b0, bus.illegal}, 32'd1);
    check("srai_rw", {31'b0, bus.reg_write}, 32'd0);
`endif
    step();

    drive(mk(7'h23, 3'd2, 1'b0), 32'h10, 32'hDEAD_BEEF, 32'd4);
    check("sw_rw", {31'b0, bus.reg_write}, 32'd0);
    step();
    drive(mk(7'h03, 3'd2, 1'b0), 32'h14, 32'h0, 32'h0);
    check("lw_wb", bus.wb_data, 32'hDEAD_BEEF);
    check("lw_rw", {31'b0, bus.reg_write}, 32'd1);
    step();

    drive(mk(7'h23, 3'd2, 1'b0), 32'h100, 32'hCAFE_F00D, 32'h0);
    step();
    drive(mk(7'h03, 3'd2, 1'b0), 32'h0, 32'h0, 32'h0);
    check("alias_wb", bus.wb_data, 32'hCAFE_F00D);
    step();

    drive(mk(7'h63, 3'd0, 1'b0), 32'd9, 32'd9, 32'h0);
    check("beq_eq_br", {31'b0, bus.branch_taken}, 32'd1);
    check("beq_eq_rw", {31'b0, bus.reg_write}, 32'd0);
    step();
    drive(mk(7'h63, 3'd0, 1'b0), 32'd9, 32'd8, 32'h0);
    check("beq_ne_br", {31'b0, bus.branch_taken}, 32'd0);
    step();

    // Reset pulse between edges clears memory
    drive(mk(7'h23, 3'd2, 1'b0), 32'd12, 32'h1234, 32'h0);
    step();
    drive(mk(7'h03, 3'd2, 1'b0), 32'd12, 32'h0, 32'h0);
    check("w3_before_rst", bus.wb_data, 32'h1234);
    rst_n = 1'b0;
    #1;
    clear_ref();
    check("w3_in_rst", bus.wb_data, 32'h0);
    rst_n = 1'b1;
    #1;
    check("w3_after_rst", bus.wb_data, 32'h0);
    step();

    drive(32'h0000_007F, 32'h0, 32'h5555_5555, 32'h0);
    check("op7f_ill", {31'b0, bus.illegal}, 32'd1);
    check("op7f_rw", {31'b0, bus.reg_write}, 32'd0);
    check("op7f_br", {31'b0, bus.branch_taken}, 32'd0);
    step();
    drive(mk(7'h03, 3'd2, 1'b0), 32'h0, 32'h0, 32'h0);
    check("op7f_nowrite", bus.wb_data, 32'h0);
    step();

    // Reset held across the edge suppresses a pending store
    drive(mk(7'h23, 3'd2, 1'b0), 32'h20, 32'h0000_BBBB, 32'h0);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_ref();
    drive(mk(7'h03, 3'd2, 1'b0), 32'h20, 32'h0, 32'h0);
    check("rst_suppress_wb", bus.wb_data, 32'h0);
    step();

    for (int n = 0; n < 400; n++) begin
      opc = opcs[$urandom_range(0, 5)];
      if (opc == 7'h00) opc = 7'($urandom);
      ins = $urandom;
      ins[6:0] = opc;
      if ($urandom_range(0, 3) != 0) ins[14:12] = (opc == 7'h63) ? 3'd0 : (opc == 7'h03 || opc == 7'h23) ? 3'd2 : ins[14:12];
      r1 = $urandom;
      r2 = $urandom;
      im = $urandom;
      if (opc == 7'h03 || opc == 7'h23) begin
        r1 = $urandom_range(0, 2047);
        im = $urandom_range(0, 255);
      end
      if ($urandom_range(0, 3) == 0) r2 = r1;
      drive(ins, r1, r2, im);
      check_model("rand");
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_control_mem.md
# alu_control_mem

Execute/memory slice of the mini single-cycle RV32I CPU. It decodes the current instruction into control signals, runs the ALU on the register-file operands and immediate, and reads or writes a small word-addressed data memory. It produces the write-back value, register-write enable and branch decision that return to the register file and program counter.

## Interface
- `DEPTH`, 64: data memory depth in 32-bit words; power of two.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `instr`  in  32: current instruction.
- `rs1_data`  in  32: register-file read port 1.
- `rs2_data`  in  32: register-file read port 2.
- `imm`  in  32: sign-extended immediate from the immediate generator.
- `alu_result`  out  32: ALU output; also the memory byte address.
- `zero`  out  1: `alu_result == 0`.
- `wb_data`  out  32: memory read word for loads, otherwise `alu_result`.
- `reg_write`  out  1: register-file write enable.
- `branch_taken`  out  1: high for BEQ with `zero`=1.
- `illegal`  out  1: opcode, funct3 or funct7 not supported.

## Operation
Control decodes `instr[6:0]` opcode, `instr[14:12]` funct3 and `instr[30]`:
- R-type (0110011): operands `rs1_data`, `rs2_data`; `reg_write`=1.
- I-ALU (0010011): operands `rs1_data`, `imm`; `reg_write`=1; `instr[30]` selects SRAI vs SRLI only.
- LW (0000011, funct3 010): add with `imm`; `reg_write`=1; `wb_data` is the memory word.
- SW (0100011, funct3 010): add with `imm`; memory write of `rs2_data`; `reg_write`=0.
- BEQ (1100011, funct3 000): SUB of `rs1_data` and `rs2_data`; `reg_write`=0; `branch_taken` = `zero`.

ALU operations:
- ADD/SUB: two's complement, 32-bit result, carry discarded.
- AND, OR, XOR: bitwise.
- SLT: signed compare, result 1 or 0.
- SLTU: unsigned compare, result 1 or 0.
- SLL, SRL, SRA: shift amount is operand B `[4:0]`.

Illegal instructions:
- Any other encoding asserts `illegal`.
- Forces `reg_write`=0, memory write 0 and `branch_taken`=0.
- `alu_result` is ADD of the selected operands.

Data memory:
- Word index is `alu_result[$clog2(DEPTH)+1:2]`.
- Address bits [1:0] are ignored; higher address bits wrap modulo DEPTH.

## Timing
- Decode, ALU, `zero`, `branch_taken`, `illegal` and memory read are combinational from `instr`, `rs1_data`, `rs2_data`, `imm` and memory contents.
- Memory write happens at the `clk` rising edge when a legal SW is present and `rst_n`=1.
- LW to an address returns the new word combinationally after the edge that wrote it.
- Same-cycle LW and SW cannot occur (single instruction per cycle).
- `rst_n`=0 clears every memory word to 0 immediately, independent of `clk`.
- Reset asserted mid-cycle suppresses any pending write.
- The block holds no other state, so outputs follow the inputs during reset, with loads reading 0.

## Configuration
- `MINI_CPU_SHIFT_EN` defined: SLL, SRL, SRA, SLLI, SRLI and SRAI are implemented.
- Undefined: the shifter is removed, and those encodings assert `illegal` and suppress register write.

## Structure
- Package `mini_cpu_pkg` holds:
  - `alu_op_t` enum (ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA).
  - Opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH).
  - The funct3 constants.
- One sub-module, `alu`:
  - Inputs `a`, `b`, `alu_op_t op`.
  - Outputs `result`, `zero`.
- Control decode and memory stay in the top module.

## Test plan
- ADD x, rs1=7, rs2=5 → `alu_result`=12, `wb_data`=12, `reg_write`=1; SUB rs1=5, rs2=7 → 0xFFFFFFFE.
- SLT rs1=0xFFFFFFFF, rs2=1 → 1; SLTU with the same operands → 0; SRAI 0x80000000 by 4 → 0xF8000000 (shift enabled).
- SW rs1=0x10, imm=4, rs2=0xDEADBEEF, one clock, then LW rs1=0x14, imm=0 → `wb_data`=0xDEADBEEF, `reg_write`=1.
- SW to byte address 0x100 with DEPTH=64 aliases word 0: LW from address 0 returns the stored value.
- BEQ rs1=rs2=9 → `branch_taken`=1, `reg_write`=0; rs1=9, rs2=8 → `branch_taken`=0.
- Store 0x1234 to word 3, pulse `rst_n` low without a clock edge → LW word 3 returns 0; opcode 0x7F → `illegal`=1, no write.
